// File: rtl/uart_match_rx_if.sv
// uart_match_rx_if: configuration and result bus of the UART match stage.
// master: drives baud_cnt/mask/match/trig_clr and reads rx_data/rdy/frm_err/UARTtrig.
// slave: the receiver side (uart_match_rx).
interface uart_match_rx_if #(
    parameter int BAUD_W = 16
);
    logic [BAUD_W-1:0] baud_cnt;
    logic [7:0]        mask;
    logic [7:0]        match;
    logic              trig_clr;
    logic [7:0]        rx_data;
    logic              rdy;
    logic              frm_err;
    logic              UARTtrig;

    modport master (
        output baud_cnt, mask, match, trig_clr,
        input  rx_data, rdy, frm_err, UARTtrig
    );

    modport slave (
        input  baud_cnt, mask, match, trig_clr,
        output rx_data, rdy, frm_err, UARTtrig
    );
endinterface

// File: rtl/uart_match_rx.sv
// uart_match_rx: UART (8N1, LSB first) receiver with masked byte match and a
// sticky trigger flag for the protocol trigger path.
// Ports: clk, rst_n (synchronous, active-high), RX (async serial line),
//   bus (slave): baud_cnt, mask, match, trig_clr in; rx_data, rdy, frm_err,
//   UARTtrig out.
// Option: define UART_PARITY_EN for 8E1 frames with even-parity checking.
module uart_match_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int BAUD_W      = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           RX,
    uart_match_rx_if.slave bus
);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [BAUD_W-1:0] ONE = BAUD_W'(1);
    localparam logic [BAUD_W-1:0] TWO = BAUD_W'(2);

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev;
    logic [BAUD_W-1:0]      period;
    logic [BAUD_W-1:0]      cnt;
    logic [BAUD_W-1:0]      p_new;
    logic [3:0]             idx;
    logic [7:0]             shifter;
    logic                   hit;
    logic                   stop_ok;
    logic [7:0]             rx_data_q;
    logic                   rdy_q;
    logic                   frm_q;
    logic                   trig_q;
`ifdef UART_PARITY_EN
    logic                   par_ok;
`endif

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        p_new = (bus.baud_cnt < TWO) ? TWO : bus.baud_cnt;
        hit   = ((shifter ^ bus.match) & ~bus.mask) == 8'h00;
`ifdef UART_PARITY_EN
        stop_ok = rx_s & par_ok;
`else
        stop_ok = rx_s;
`endif
    end

    // Counters reload with period-1 so samples are exactly P clocks apart;
    // the start-bit wait of P/2-1 lands the first sample mid-bit.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= IDLE;
            sync_q    <= '1;
            rx_prev   <= 1'b1;
            period    <= TWO;
            cnt       <= '0;
            idx       <= '0;
            shifter   <= '0;
            rx_data_q <= '0;
            rdy_q     <= 1'b0;
            frm_q     <= 1'b0;
            trig_q    <= 1'b0;
`ifdef UART_PARITY_EN
            par_ok    <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], RX};
            rx_prev <= rx_s;
            rdy_q   <= 1'b0;
            frm_q   <= 1'b0;
            // A hit in the STOP branch below overrides this clear.
            if (bus.trig_clr) trig_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rx_prev && !rx_s) begin
                        period <= p_new;
                        cnt    <= (p_new >> 1) - ONE;
                        state  <= START;
                    end
                end
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - ONE;
                    end else if (rx_s) begin
                        state <= IDLE;
                    end else begin
                        cnt   <= period - ONE;
                        idx   <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - ONE;
                    end else begin
                        shifter <= {rx_s, shifter[7:1]};
                        cnt     <= period - ONE;
                        idx     <= idx + 4'd1;
                        if (idx == 4'd7) begin
`ifdef UART_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - ONE;
                    end else begin
                        par_ok <= (rx_s == ^shifter);
                        cnt    <= period - ONE;
                        state  <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - ONE;
                    end else begin
                        state <= IDLE;
                        if (stop_ok) begin
                            rx_data_q <= shifter;
                            rdy_q     <= 1'b1;
                            if (hit) trig_q <= 1'b1;
                        end else begin
                            frm_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rdy      = rdy_q;
    assign bus.frm_err  = frm_q;
    assign bus.UARTtrig = trig_q;

endmodule

// File: tb/tb_uart_match_rx.sv
// tb_uart_match_rx: directed and randomized frames for uart_match_rx,
// checked against a byte-level model of the receive and match rules.
module tb_uart_match_rx;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic RX = 1'b1;

    uart_match_rx_if #(.BAUD_W(16)) bus ();

    uart_match_rx #(
        .SYNC_STAGES(2),
        .BAUD_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .RX(RX),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int n_rdy = 0;
    int n_ferr = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_data = 8'h00;
    logic exp_trig = 1'b0;
    int cur_p = 2;

    always @(negedge clk) begin
        if (bus.rdy) begin
            n_rdy++;
            got_q.push_back(bus.rx_data);
        end
        if (bus.frm_err) n_ferr++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_p(input int b);
        return (b < 2) ? 2 : b;
    endfunction

    task automatic set_cfg(input int baud, input logic [7:0] m,
                           input logic [7:0] mt);
        bus.baud_cnt = 16'(baud);
        bus.mask = m;
        bus.match = mt;
        cur_p = eff_p(baud);
    endtask

    task automatic clr_trig();
        bus.trig_clr = 1'b1;
        @(negedge clk);
        bus.trig_clr = 1'b0;
        exp_trig = 1'b0;
    endtask

    task automatic clear_mon();
        n_rdy = 0;
        n_ferr = 0;
        got_q.delete();
    endtask

    // Drive one frame, each bit held for p clocks.
    task automatic send_bits(input logic [7:0] b, input logic stop,
                             input logic par_flip, input int p);
        RX = 1'b0;
        repeat (p) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (p) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        RX = (^b) ^ par_flip;
        repeat (p) @(negedge clk);
`endif
        RX = stop;
        repeat (p) @(negedge clk);
        RX = 1'b1;
    endtask

    // Model: a frame is accepted when its stop bit is 1 (and, with parity,
    // the parity bit is even); accepted bytes update rx_data and may set trig.
    task automatic model_byte(input logic [7:0] b);
        exp_data = b;
        if (((b ^ bus.match) & ~bus.mask) == 8'h00) exp_trig = 1'b1;
    endtask

    task automatic frame(input string tag, input logic [7:0] b,
                         input logic stop, input logic par_flip);
        logic valid;
        clear_mon();
        send_bits(b, stop, par_flip, cur_p);
        repeat (12) @(negedge clk);
`ifdef UART_PARITY_EN
        valid = stop && !par_flip;
`else
        valid = stop;
`endif
        if (valid) model_byte(b);
        chk({tag, ".rdy"}, n_rdy, valid ? 1 : 0);
        chk({tag, ".frm_err"}, n_ferr, valid ? 0 : 1);
        chk({tag, ".rx_data"}, bus.rx_data, exp_data);
        chk({tag, ".trig"}, bus.UARTtrig, exp_trig);
    endtask

    initial begin
        bus.trig_clr = 1'b0;
        set_cfg(10, 8'h00, 8'hA5);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset.rx_data", bus.rx_data, 8'h00);
        chk("reset.rdy", bus.rdy, 1'b0);
        chk("reset.frm_err", bus.frm_err, 1'b0);
        chk("reset.trig", bus.UARTtrig, 1'b0);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);

        frame("a5_hit", 8'hA5, 1'b1, 1'b0);
        frame("3c_keep", 8'h3C, 1'b1, 1'b0);
        clr_trig();
        @(negedge clk);
        chk("clr.trig", bus.UARTtrig, exp_trig);
        frame("a4_miss", 8'hA4, 1'b1, 1'b0);

        set_cfg(10, 8'h0F, 8'h50);
        frame("5c_masked", 8'h5C, 1'b1, 1'b0);
        clr_trig();
        frame("6c_miss", 8'h6C, 1'b1, 1'b0);

        set_cfg(10, 8'hFF, 8'h00);
        clr_trig();
        frame("3c_stop0", 8'h3C, 1'b0, 1'b0);

        clear_mon();
        RX = 1'b0;
        repeat (3) @(negedge clk);
        RX = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch.rdy", n_rdy, 0);
        chk("glitch.frm_err", n_ferr, 0);

        frame("ff_any", 8'hFF, 1'b1, 1'b0);
        clear_mon();
        fork
            send_bits(8'hF0, 1'b1, 1'b0, cur_p);
            begin
                repeat (5 * cur_p + cur_p / 2 + 1) @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                exp_data = 8'h00;
                exp_trig = 1'b0;
                chk("midrst.rx_data", bus.rx_data, exp_data);
                chk("midrst.rdy", bus.rdy, 1'b0);
                chk("midrst.frm_err", bus.frm_err, 1'b0);
                chk("midrst.trig", bus.UARTtrig, exp_trig);
                rst_n = 1'b0;
            end
        join
        repeat (12) @(negedge clk);
        chk("midrst.no_rdy", n_rdy, 0);
        chk("midrst.no_ferr", n_ferr, 0);
        set_cfg(10, 8'h00, 8'h81);
        frame("81_after_rst", 8'h81, 1'b1, 1'b0);

        set_cfg(1, 8'hFF, 8'h00);
        clr_trig();
        clear_mon();
        send_bits(8'h00, 1'b1, 1'b0, cur_p);
        send_bits(8'hFF, 1'b1, 1'b0, cur_p);
        repeat (12) @(negedge clk);
        model_byte(8'h00);
        model_byte(8'hFF);
        chk("b2b.count", n_rdy, 2);
        chk("b2b.ferr", n_ferr, 0);
        chk("b2b.first", (got_q.size() > 0) ? got_q[0] : 8'hXX, 8'h00);
        chk("b2b.second", (got_q.size() > 1) ? got_q[1] : 8'hXX, 8'hFF);
        chk("b2b.trig", bus.UARTtrig, exp_trig);

`ifdef UART_PARITY_EN
        set_cfg(10, 8'hFF, 8'h00);
        clr_trig();
        frame("par_bad_01", 8'h01, 1'b1, 1'b1);
        frame("par_ok_01", 8'h01, 1'b1, 1'b0);
`endif

        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            logic [7:0] m;
            logic [7:0] mt;
            logic stop;
            logic pf;
            b = 8'($urandom);
            case ($urandom_range(0, 3))
                0: m = 8'h00;
                1: m = 8'hFF;
                default: m = 8'($urandom);
            endcase
            if ($urandom_range(0, 1) == 1) mt = b ^ (8'($urandom) & m);
            else mt = 8'($urandom);
            set_cfg($urandom_range(0, 12), m, mt);
            stop = ($urandom_range(0, 7) != 0);
`ifdef UART_PARITY_EN
            pf = ($urandom_range(0, 7) == 0);
`else
            pf = 1'b0;
`endif
            if ($urandom_range(0, 3) == 0) clr_trig();
            repeat ($urandom_range(0, 5)) @(negedge clk);
            frame($sformatf("rnd%0d", n), b, stop, pf);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
